// File: rtl/bus_if_pkg.sv
// Shared widths, FSM state encoding and access codes for the pipeline bus interface.
package bus_if_pkg;

    localparam int WORD_ADDR_W    = 30;
    localparam int WORD_DATA_W    = 32;
    localparam int BUS_IF_STATE_W = 2;

    typedef logic [WORD_ADDR_W-1:0] word_addr_t;
    typedef logic [WORD_DATA_W-1:0] word_data_t;

    typedef enum logic [BUS_IF_STATE_W-1:0] {
        BUS_IF_IDLE   = 2'd0,
        BUS_IF_REQ    = 2'd1,
        BUS_IF_ACCESS = 2'd2,
        BUS_IF_STALL  = 2'd3
    } bus_if_state_e;

    localparam logic [2:0] SPM_AREA_DEFAULT = 3'b011;

    localparam logic READ  = 1'b1;
    localparam logic WRITE = 1'b0;

endpackage

// File: rtl/bus_if.sv
// Pipeline-stage bus interface: decodes scratch-pad accesses combinationally and
// runs external bus transfers through a request/grant/strobe/ready handshake.
module bus_if
    import bus_if_pkg::*;
#(
    parameter logic [2:0] SPM_AREA = SPM_AREA_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall,
    input  logic                   flush,
    output logic                   busy,
    input  logic [WORD_ADDR_W-1:0] addr,
    input  logic                   as_,
    input  logic                   rw,
    input  logic [WORD_DATA_W-1:0] wr_data,
    output logic [WORD_DATA_W-1:0] rd_data,
    input  logic [WORD_DATA_W-1:0] spm_rd_data,
    output logic [WORD_ADDR_W-1:0] spm_addr,
    output logic                   spm_as_,
    output logic                   spm_rw,
    output logic [WORD_DATA_W-1:0] spm_wr_data,
    input  logic [WORD_DATA_W-1:0] bus_rd_data,
    input  logic                   bus_rdy_,
    input  logic                   bus_grnt_,
    output logic                   bus_req_,
    output logic [WORD_ADDR_W-1:0] bus_addr,
    output logic                   bus_as_,
    output logic                   bus_rw,
    output logic [WORD_DATA_W-1:0] bus_wr_data
);

    bus_if_state_e          r_state;
    bus_if_state_e          w_state_next;
    logic [WORD_DATA_W-1:0] r_rd_buf;
    logic                   w_spm_sel;
    logic                   w_go;

    assign w_spm_sel = (addr[WORD_ADDR_W-1:WORD_ADDR_W-3] == SPM_AREA);
    // A stalled or flushed stage must not launch any new access.
    assign w_go      = !as_ && !flush && !stall;

    assign spm_addr    = addr;
    assign spm_rw      = rw;
    assign spm_wr_data = wr_data;
    assign spm_as_     = !(w_go && w_spm_sel);

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        rd_data      = w_spm_sel ? spm_rd_data : '0;
        case (r_state)
            BUS_IF_IDLE: begin
                if (w_go && !w_spm_sel) begin
                    busy         = 1'b1;
                    w_state_next = BUS_IF_REQ;
                end
            end
            BUS_IF_REQ: begin
                busy = 1'b1;
                if (!bus_grnt_)
                    w_state_next = BUS_IF_ACCESS;
                else if (flush)
                    w_state_next = BUS_IF_IDLE;
            end
            BUS_IF_ACCESS: begin
                // Flush is deliberately ignored here: a started bus cycle always finishes.
                if (!bus_rdy_) begin
                    rd_data      = bus_rd_data;
                    w_state_next = stall ? BUS_IF_STALL : BUS_IF_IDLE;
                end else begin
                    busy = 1'b1;
                end
            end
            BUS_IF_STALL: begin
                rd_data = r_rd_buf;
                if (!stall)
                    w_state_next = BUS_IF_IDLE;
            end
            default: w_state_next = BUS_IF_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: every register here is cleared so a reset mid-transfer leaves no stale bus values.
            r_state     <= BUS_IF_IDLE;
            bus_req_    <= 1'b1;
            bus_as_     <= 1'b1;
            bus_rw      <= READ;
            bus_addr    <= '0;
            bus_wr_data <= '0;
            r_rd_buf    <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                BUS_IF_IDLE: begin
                    if (w_state_next == BUS_IF_REQ) begin
                        bus_req_    <= 1'b0;
                        bus_addr    <= addr;
                        bus_rw      <= rw;
                        bus_wr_data <= wr_data;
                    end
                end
                BUS_IF_REQ: begin
                    if (!bus_grnt_)
                        bus_as_ <= 1'b0;
                    else if (flush)
                        bus_req_ <= 1'b1;
                end
                BUS_IF_ACCESS: begin
                    bus_as_ <= 1'b1;
                    if (!bus_rdy_) begin
                        bus_req_ <= 1'b1;
                        r_rd_buf <= bus_rd_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_if.sv
// Directed scoreboard bench for bus_if: expectations are queued while driving each
// cycle and drained against the DUT on the following falling edge.
module tb_bus_if;

    localparam logic [31:0] ST_IDLE   = 32'd0;
    localparam logic [31:0] ST_REQ    = 32'd1;
    localparam logic [31:0] ST_ACCESS = 32'd2;
    localparam logic [31:0] ST_STALL  = 32'd3;

    logic        clk = 1'b0;
    logic        reset, stall, flush, as_, rw, bus_rdy_, bus_grnt_;
    logic [29:0] addr;
    logic [31:0] wr_data, spm_rd_data, bus_rd_data;
    logic        busy, spm_as_, spm_rw, bus_req_, bus_as_, bus_rw;
    logic [31:0] rd_data, spm_wr_data, bus_wr_data;
    logic [29:0] spm_addr, bus_addr;

    int errors = 0;
    int checks = 0;

    typedef enum {S_BUSY, S_RD_DATA, S_SPM_AS, S_SPM_ADDR, S_BUS_REQ, S_BUS_AS,
                  S_BUS_RW, S_BUS_ADDR, S_BUS_WDATA, S_STATE} sig_e;
    typedef struct {
        sig_e        sig;
        logic [31:0] exp;
    } exp_t;
    exp_t sb[$];

    bus_if dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .busy(busy),
        .addr(addr), .as_(as_), .rw(rw), .wr_data(wr_data), .rd_data(rd_data),
        .spm_rd_data(spm_rd_data), .spm_addr(spm_addr), .spm_as_(spm_as_),
        .spm_rw(spm_rw), .spm_wr_data(spm_wr_data), .bus_rd_data(bus_rd_data),
        .bus_rdy_(bus_rdy_), .bus_grnt_(bus_grnt_), .bus_req_(bus_req_),
        .bus_addr(bus_addr), .bus_as_(bus_as_), .bus_rw(bus_rw),
        .bus_wr_data(bus_wr_data)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] observe(input sig_e s);
        case (s)
            S_BUSY:      return {31'b0, busy};
            S_RD_DATA:   return rd_data;
            S_SPM_AS:    return {31'b0, spm_as_};
            S_SPM_ADDR:  return {2'b0, spm_addr};
            S_BUS_REQ:   return {31'b0, bus_req_};
            S_BUS_AS:    return {31'b0, bus_as_};
            S_BUS_RW:    return {31'b0, bus_rw};
            S_BUS_ADDR:  return {2'b0, bus_addr};
            S_BUS_WDATA: return bus_wr_data;
            S_STATE:     return {30'b0, dut.r_state};
            default:     return '0;
        endcase
    endfunction

    task automatic expect_sig(input sig_e s, input logic [31:0] v);
        exp_t e;
        e.sig = s;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic check();
        exp_t        e;
        logic [31:0] obs;
        @(negedge clk);
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.sig);
            checks++;
            assert (obs === e.exp) else begin
                errors++;
                $error("FAIL %s @%0t: observed %h expected %h", e.sig.name(), $time, obs, e.exp);
            end
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; flush = 1'b0; as_ = 1'b1; rw = 1'b1;
        bus_rdy_ = 1'b1; bus_grnt_ = 1'b1; addr = '0; wr_data = '0;
        spm_rd_data = '0; bus_rd_data = '0;

        // Reset values
        next_cycle();
        expect_sig(S_BUS_REQ, 1); expect_sig(S_BUS_AS, 1); expect_sig(S_BUS_RW, 1);
        expect_sig(S_BUS_ADDR, 0); expect_sig(S_BUS_WDATA, 0);
        expect_sig(S_STATE, ST_IDLE); expect_sig(S_BUSY, 0);
        check();
        next_cycle();
        reset = 1'b0;

        // SPM read: strobe and data in the same cycle, no busy
        addr = 30'h18000010; as_ = 1'b0; rw = 1'b1; spm_rd_data = 32'h1234_5678;
        expect_sig(S_SPM_AS, 0); expect_sig(S_BUSY, 0); expect_sig(S_RD_DATA, 32'h1234_5678);
        expect_sig(S_SPM_ADDR, 32'h1800_0010); expect_sig(S_BUS_REQ, 1);
        check();
        next_cycle();
        stall = 1'b1;
        expect_sig(S_SPM_AS, 1); expect_sig(S_STATE, ST_IDLE);
        check();
        next_cycle();
        stall = 1'b0; flush = 1'b1;
        expect_sig(S_SPM_AS, 1); expect_sig(S_BUSY, 0);
        check();

        // Bus read: grant at cycle 1, ready at cycle 3
        next_cycle();
        flush = 1'b0; addr = 30'h00000040; bus_rd_data = '0;
        expect_sig(S_BUSY, 1); expect_sig(S_RD_DATA, 0); expect_sig(S_BUS_REQ, 1);
        expect_sig(S_STATE, ST_IDLE);
        check();
        next_cycle();
        bus_grnt_ = 1'b0;
        expect_sig(S_STATE, ST_REQ); expect_sig(S_BUSY, 1); expect_sig(S_BUS_REQ, 0);
        expect_sig(S_BUS_ADDR, 32'h40); expect_sig(S_BUS_RW, 1); expect_sig(S_BUS_AS, 1);
        check();
        next_cycle();
        bus_grnt_ = 1'b1;
        expect_sig(S_STATE, ST_ACCESS); expect_sig(S_BUS_AS, 0); expect_sig(S_BUSY, 1);
        check();
        next_cycle();
        bus_rdy_ = 1'b0; bus_rd_data = 32'hDEAD_BEEF;
        expect_sig(S_BUS_AS, 1); expect_sig(S_BUSY, 0); expect_sig(S_RD_DATA, 32'hDEAD_BEEF);
        expect_sig(S_STATE, ST_ACCESS);
        check();
        next_cycle();
        bus_rdy_ = 1'b1; as_ = 1'b1; bus_rd_data = '0;
        expect_sig(S_STATE, ST_IDLE); expect_sig(S_BUS_REQ, 1); expect_sig(S_BUSY, 0);
        expect_sig(S_RD_DATA, 0);
        check();

        // Minimum-latency read ending in a two-cycle stall
        next_cycle();
        addr = 30'h00000100; as_ = 1'b0; bus_grnt_ = 1'b0;
        expect_sig(S_BUSY, 1);
        check();
        next_cycle();
        expect_sig(S_STATE, ST_REQ); expect_sig(S_BUSY, 1);
        check();
        next_cycle();
        bus_rdy_ = 1'b0; bus_rd_data = 32'hDEAD_BEEF; stall = 1'b1;
        expect_sig(S_STATE, ST_ACCESS); expect_sig(S_BUS_AS, 0); expect_sig(S_BUSY, 0);
        expect_sig(S_RD_DATA, 32'hDEAD_BEEF);
        check();
        next_cycle();
        bus_rdy_ = 1'b1; bus_rd_data = 32'h0BAD_F00D;
        expect_sig(S_STATE, ST_STALL); expect_sig(S_BUSY, 0);
        expect_sig(S_RD_DATA, 32'hDEAD_BEEF); expect_sig(S_BUS_REQ, 1);
        check();
        next_cycle();
        stall = 1'b0;
        expect_sig(S_STATE, ST_STALL); expect_sig(S_RD_DATA, 32'hDEAD_BEEF); expect_sig(S_BUSY, 0);
        check();
        next_cycle();
        as_ = 1'b1; bus_grnt_ = 1'b1;
        expect_sig(S_STATE, ST_IDLE);
        check();

        // Flush in REQ before grant abandons the request
        next_cycle();
        addr = 30'h00000200; as_ = 1'b0;
        expect_sig(S_BUSY, 1);
        check();
        next_cycle();
        flush = 1'b1;
        expect_sig(S_STATE, ST_REQ); expect_sig(S_BUS_REQ, 0);
        check();
        next_cycle();
        flush = 1'b0; as_ = 1'b1;
        expect_sig(S_STATE, ST_IDLE); expect_sig(S_BUS_REQ, 1); expect_sig(S_BUS_AS, 1);
        expect_sig(S_BUSY, 0);
        check();
        next_cycle();
        expect_sig(S_BUS_AS, 1); expect_sig(S_STATE, ST_IDLE);
        check();

        // Write with flush during ACCESS: transfer still completes
        next_cycle();
        addr = 30'h00000300; rw = 1'b0; wr_data = 32'hA5A5_5A5A; as_ = 1'b0; bus_grnt_ = 1'b0;
        expect_sig(S_BUSY, 1);
        check();
        next_cycle();
        expect_sig(S_STATE, ST_REQ); expect_sig(S_BUS_RW, 0);
        expect_sig(S_BUS_WDATA, 32'hA5A5_5A5A); expect_sig(S_BUS_ADDR, 32'h300);
        check();
        next_cycle();
        flush = 1'b1; bus_grnt_ = 1'b1;
        expect_sig(S_STATE, ST_ACCESS); expect_sig(S_BUS_AS, 0); expect_sig(S_BUSY, 1);
        check();
        next_cycle();
        bus_rdy_ = 1'b0;
        expect_sig(S_STATE, ST_ACCESS); expect_sig(S_BUSY, 0); expect_sig(S_BUS_AS, 1);
        check();
        next_cycle();
        flush = 1'b0; bus_rdy_ = 1'b1; as_ = 1'b1; rw = 1'b1;
        expect_sig(S_STATE, ST_IDLE); expect_sig(S_BUS_REQ, 1);
        check();

        // Reset asserted while in ACCESS
        next_cycle();
        addr = 30'h00000400; as_ = 1'b0; bus_grnt_ = 1'b0;
        expect_sig(S_BUSY, 1);
        check();
        next_cycle();
        expect_sig(S_STATE, ST_REQ);
        check();
        next_cycle();
        expect_sig(S_STATE, ST_ACCESS); expect_sig(S_BUS_REQ, 0); expect_sig(S_BUS_AS, 0);
        check();
        next_cycle();
        reset = 1'b1; as_ = 1'b1;
        expect_sig(S_STATE, ST_IDLE); expect_sig(S_BUS_REQ, 1); expect_sig(S_BUS_AS, 1);
        expect_sig(S_BUS_ADDR, 0); expect_sig(S_BUSY, 0);
        check();
        next_cycle();
        reset = 1'b0; bus_grnt_ = 1'b1;
        expect_sig(S_STATE, ST_IDLE); expect_sig(S_BUS_REQ, 1);
        check();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
